ram_mutex_client: RTL and testbench
===================================

# ram_mutex_client

Per-node bus master that sits directly upstream of the shared RAM mutex and drives one of its 16-bit op-word inputs. It queues frame-stack commands from node logic in a small FIFO, then acquires the mutex with a prioritised start word and issues the queued commands one per slot. It returns read data to the node and releases the lock with the stop word. One instance exists per node; its `out_op` connects to `in_op_nodeN` and its `in_node` connects to the mutex's shared `out_node`.

## Interface
- `NODE_ID`, default 0: node index, 0 or 1. Sets GRANT_CODE to 8'h01 when 0 and 8'h02 when 1.
- `FIFO_DEPTH`, default 4: command FIFO entries, a power of two, 2..16.
- `BURST_MAX`, default 8: maximum commands issued per lock session, 1..255.
- `CLK` input 1: single clock. All state changes on the rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: FIFO not full.
- `cmd_op` input 2: 00 read, 01 write, 10 garbage working frame, 11 add new frame.
- `cmd_arg` input 8: read offset or write data. Ignored for ops 10 and 11.
- `prio` input 4: request priority. Sampled on REQ entry; a value of 0 is promoted to 1.
- `in_node` input 16: mutex response word.
- `out_op` output 16: op word to the mutex.
- `rsp_valid` output 1: one-cycle pulse carrying read data.
- `rsp_data` output 8: read data, held until the next pulse.
- `busy` output 1: high in any state other than IDLE.

## Operation
- Fixed words:
  - IDLE_W = 16'h0000
  - NOP_W = 16'hFC00
  - STOP_W = 16'hFCFF
  - START_W = {12'hFC0, prio_q}
  - OP_W = {2'b00, op, 4'b1100, arg}
- FIFO: a push occurs on `cmd_valid && cmd_ready`, and a pop occurs in OP. A push and a pop in the same cycle leave the count unchanged. `cmd_ready = (count != FIFO_DEPTH)`. Commands are issued in strict arrival order.
- State machine and `out_op` driven in each state:
  - IDLE (IDLE_W): go to REQ if the FIFO is non-empty and IDLE has lasted at least 1 cycle since the last REL. Latch prio_q. Clear burst_cnt.
  - REQ (START_W): hold until `in_node[15:8] == GRANT_CODE`, then go to OP. There is no timeout; losing arbitration simply extends REQ.
  - OP (OP_W of the FIFO head, exactly 1 cycle): pop the head, increment burst_cnt, latch is_read = (op == 00), go to GAP.
  - GAP (NOP_W, exactly 1 cycle): if is_read, register `rsp_data <= in_node[7:0]` and `rsp_valid <= 1`.
    - Go to OP if the FIFO is non-empty and burst_cnt < BURST_MAX.
    - Otherwise go to REL.
  - REL (STOP_W, exactly 1 cycle): go to IDLE.
- Every op word is driven for exactly one cycle. The mutex executes on every cycle a non-NOP word is present, so a held op word would be executed again.
- burst_cnt is 8 bits wide and saturates; it never wraps.
- Commands arriving during a session are eligible for that session if they are present when GAP evaluates.

## Timing
- Reset values, applied asynchronously:
  - `out_op` = 16'h0000
  - `cmd_ready` = 1
  - `rsp_valid` = 0
  - `rsp_data` = 8'h00
  - `busy` = 0
  - FIFO empty, state IDLE, prio_q = 1, burst_cnt = 0
- `out_op` is registered; it changes only on a `CLK` edge or on `RST`.
- Uncontended grant latency: START_W first appears in cycle t. `in_node` shows GRANT_CODE in cycle t+2. OP_W is driven in cycle t+3.
- Read latency: OP_W in cycle u. Data is valid on `in_node` in cycle u+1 (GAP). `rsp_valid` is high in cycle u+2.
- Steady-state throughput: one command every 2 cycles. Session overhead is 3 cycles of request plus 1 of release plus at least 1 of IDLE.
- Reset mid-session: `out_op` drops to IDLE_W immediately. The mutex must be reset in the same system reset, because no STOP_W is sent.
- `rsp_valid` is never asserted for commands of type 01, 10 or 11.

## Test plan
- Single write, NODE_ID=0, prio=5, arg=8'h3A, mutex model granting after 2 cycles:
  - `out_op` sequence 0000, FC05 ×3, 1C3A, FC00, FCFF, 0000.
  - `rsp_valid` stays 0.
- Write 8'h11, then read offset 0, in one session:
  - Words 1C11, FC00, 0C00, FC00, FCFF.
  - `rsp_valid` pulses once with `rsp_data` = 8'h11, two cycles after 0C00.
- Burst cap with BURST_MAX=2 and 3 writes queued:
  - 2 ops, FCFF, 0000 for at least 1 cycle, then a new START_W and the third op in a second session.
- Contention: the model grants the other node for 10 cycles.
  - `out_op` holds FC05 throughout.
  - No op word is emitted until `in_node[15:8]` = 8'h01.
- FIFO full, FIFO_DEPTH=4, no grant: after 4 pushes `cmd_ready` = 0 and a 5th `cmd_valid` is not accepted. After the grant and the first OP, `cmd_ready` returns to 1.
- `RST` asserted during GAP: `out_op` = 0000 and `busy` = 0 asynchronously, and the FIFO is emptied. After release, nothing is issued until a new command is pushed.

Source files
------------

// File: rtl/ram_mutex_client.sv
// ram_mutex_client: per-node master for the shared RAM mutex.
// Queues node commands in a FIFO, acquires the mutex with a prioritised
// start word, then issues one command per two-cycle slot and releases the
// lock with the stop word. Read data from the mutex is returned to the node.
//
// Command handshake: a command is accepted on any rising edge where
// cmd_valid && cmd_ready. cmd_ready depends only on the FIFO fill level,
// never on cmd_valid. cmd_op and cmd_arg must be stable while cmd_valid is high.
module ram_mutex_client #(
    parameter int NODE_ID    = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_arg,
    input  logic [3:0]  prio,
    input  logic [15:0] in_node,
    output logic [15:0] out_op,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        busy,
    output logic [2:0]  fsm_state
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [7:0]  GRANT_CODE = (NODE_ID == 0) ? 8'h01 : 8'h02;
    localparam logic [7:0]  BURST_LIM  = 8'(BURST_MAX);
    localparam logic [15:0] IDLE_W     = 16'h0000;
    localparam logic [15:0] NOP_W      = 16'hFC00;
    localparam logic [15:0] STOP_W     = 16'hFCFF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_OP   = 3'd2,
        S_GAP  = 3'd3,
        S_REL  = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [15:0]     out_nxt;
    logic [3:0]      prio_q;
    logic [3:0]      prio_eff;
    logic [7:0]      burst_cnt;
    logic            is_read;

    // FIFO storage: each entry is {op, arg}
    logic [9:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            push, pop;
    logic [9:0]      head;
    logic [15:0]     head_word;

    assign cmd_ready = (count != CW'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == S_OP);
    assign head      = fifo_mem[rd_ptr];
    assign head_word = {2'b00, head[9:8], 4'b1100, head[7:0]};
    assign prio_eff  = (prio == 4'd0) ? 4'd1 : prio;
    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    // FIFO data array; contents need no reset because count gates every read
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_op, cmd_arg};
        end
    end

    // FIFO pointers and fill level; a simultaneous push and pop cancel out
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Next state and the op word to present next cycle (out_op is registered)
    always_comb begin
        state_nxt = state;
        out_nxt   = IDLE_W;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    state_nxt = S_REQ;
                    out_nxt   = {12'hFC0, prio_eff};
                end
            end
            S_REQ: begin
                if (in_node[15:8] == GRANT_CODE) begin
                    state_nxt = S_OP;
                    out_nxt   = head_word;
                end else begin
                    out_nxt   = {12'hFC0, prio_q};
                end
            end
            S_OP: begin
                state_nxt = S_GAP;
                out_nxt   = NOP_W;
            end
            S_GAP: begin
                if ((count != '0) && (burst_cnt < BURST_LIM)) begin
                    state_nxt = S_OP;
                    out_nxt   = head_word;
                end else begin
                    state_nxt = S_REL;
                    out_nxt   = STOP_W;
                end
            end
            S_REL: begin
                state_nxt = S_IDLE;
                out_nxt   = IDLE_W;
            end
            default: begin
                state_nxt = S_IDLE;
                out_nxt   = IDLE_W;
            end
        endcase
    end

    // State, op word, session bookkeeping and read response registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            out_op    <= IDLE_W;
            prio_q    <= 4'd1;
            burst_cnt <= 8'd0;
            is_read   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
        end else begin
            state     <= state_nxt;
            out_op    <= out_nxt;
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    burst_cnt <= 8'd0;
                    if (state_nxt == S_REQ) prio_q <= prio_eff;
                end
                S_OP: begin
                    if (burst_cnt != 8'hFF) burst_cnt <= burst_cnt + 8'd1;
                    is_read <= (head[9:8] == 2'b00);
                end
                S_GAP: begin
                    if (is_read) begin
                        rsp_data  <= in_node[7:0];
                        rsp_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_mutex_client.sv
// Testbench for ram_mutex_client with a small behavioural mutex model.
module tb_ram_mutex_client;

    logic        CLK;
    logic        RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_arg;
    logic [3:0]  prio;
    logic [15:0] in_node;
    logic [15:0] out_op;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        busy;
    logic [2:0]  fsm_state;

    int total = 0;
    int bad   = 0;

    logic [16:0] exp_q[$];
    logic [7:0]  rsp_q[$];

    ram_mutex_client #(
        .NODE_ID    (0),
        .FIFO_DEPTH (4),
        .BURST_MAX  (2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .prio      (prio),
        .in_node   (in_node),
        .out_op    (out_op),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // clock / watchdog
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // mutex model: grants node 0 after START_W has been seen for 2 cycles,
    // unless other_owner holds the lock; writes append, reads return ram[offset]
    logic [7:0] ram [256];
    logic [7:0] wptr;
    logic [7:0] rd_q;
    int         start_cnt;
    logic       other_owner;
    logic       is_start;
    logic       is_opw;

    assign is_start = (out_op[15:4] == 12'hFC0) && (out_op[3:0] != 4'd0);
    assign is_opw   = (out_op[15:14] == 2'b00) && (out_op[11:8] == 4'hC);
    assign in_node  = {(other_owner ? 8'h02 : ((start_cnt >= 2) ? 8'h01 : 8'h00)), rd_q};

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            start_cnt <= 0;
            wptr      <= 8'd0;
            rd_q      <= 8'd0;
        end else begin
            start_cnt <= is_start ? start_cnt + 1 : 0;
            if (is_opw && out_op[13:12] == 2'b01) begin
                ram[wptr] <= out_op[7:0];
                wptr      <= wptr + 8'd1;
            end
            if (is_opw && out_op[13:12] == 2'b00) begin
                rd_q <= ram[out_op[7:0]];
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [7:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge CLK);
        cmd_valid = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        RST = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        total++;
        if (out_op !== 16'h0000) begin bad++; $display("FAIL reset_out_op: got %h want 0000", out_op); end
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++;
        if (rsp_data !== 8'h00) begin bad++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        total++;
        if ({busy, out_op} !== 17'h0_0000) begin bad++; $display("FAIL reset_idle_hold: got busy=%b op=%h want 0/0000", busy, out_op); end
    endtask

    task automatic test_single_write();
        logic [16:0] e;
        int c = 0;
        do_reset();
        prio = 4'd5;
        push_cmd(2'b01, 8'h3A);
        exp_q = '{17'h0_0000, 17'h0_FC05, 17'h0_FC05, 17'h0_FC05, 17'h0_1C3A,
                  17'h0_FC00, 17'h0_FCFF, 17'h0_0000, 17'h0_0000};
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if ({rsp_valid, out_op} !== e) begin
                bad++;
                $display("FAIL single_write c%0d: got rv=%b op=%h want rv=%b op=%h", c, rsp_valid, out_op, e[16], e[15:0]);
            end
            c++;
            @(negedge CLK);
        end
    endtask

    task automatic test_write_read();
        logic [16:0] e;
        int c = 0;
        do_reset();
        prio = 4'd5;
        push_cmd(2'b01, 8'h11);
        push_cmd(2'b00, 8'h00);
        rsp_q.push_back(8'h11);
        exp_q = '{17'h0_FC05, 17'h0_FC05, 17'h0_FC05, 17'h0_1C11, 17'h0_FC00,
                  17'h0_0C00, 17'h0_FC00, 17'h1_FCFF, 17'h0_0000, 17'h0_0000};
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if ({rsp_valid, out_op} !== e) begin
                bad++;
                $display("FAIL write_read c%0d: got rv=%b op=%h want rv=%b op=%h", c, rsp_valid, out_op, e[16], e[15:0]);
            end
            if (rsp_valid === 1'b1) begin
                total++;
                if (rsp_q.size() == 0) begin
                    bad++;
                    $display("FAIL write_read_data c%0d: got unexpected %h want no response", c, rsp_data);
                end else if (rsp_data !== rsp_q[0]) begin
                    bad++;
                    $display("FAIL write_read_data c%0d: got %h want %h", c, rsp_data, rsp_q[0]);
                    void'(rsp_q.pop_front());
                end else begin
                    void'(rsp_q.pop_front());
                end
            end
            c++;
            @(negedge CLK);
        end
        total++;
        if (rsp_q.size() != 0) begin
            bad++;
            $display("FAIL write_read_missing: got %0d outstanding want 0", rsp_q.size());
            rsp_q.delete();
        end
        total++;
        if (rsp_data !== 8'h11) begin bad++; $display("FAIL write_read_hold: got %h want 11", rsp_data); end
    endtask

    task automatic test_burst_cap();
        logic [16:0] e;
        int c = 0;
        do_reset();
        prio = 4'd3;
        push_cmd(2'b01, 8'hAA);
        push_cmd(2'b01, 8'hBB);
        push_cmd(2'b01, 8'hCC);
        exp_q = '{17'h0_FC03, 17'h0_FC03, 17'h0_1CAA, 17'h0_FC00, 17'h0_1CBB,
                  17'h0_FC00, 17'h0_FCFF, 17'h0_0000, 17'h0_FC03, 17'h0_FC03,
                  17'h0_FC03, 17'h0_1CCC, 17'h0_FC00, 17'h0_FCFF, 17'h0_0000};
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if ({rsp_valid, out_op} !== e) begin
                bad++;
                $display("FAIL burst_cap c%0d: got rv=%b op=%h want rv=%b op=%h", c, rsp_valid, out_op, e[16], e[15:0]);
            end
            c++;
            @(negedge CLK);
        end
    endtask

    task automatic test_contention();
        logic [16:0] e;
        int c = 0;
        do_reset();
        prio = 4'd5;
        other_owner = 1'b1;
        push_cmd(2'b01, 8'h5A);
        exp_q.push_back(17'h0_0000);
        repeat (9) exp_q.push_back(17'h0_FC05);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if ({rsp_valid, out_op} !== e) begin
                bad++;
                $display("FAIL contention_hold c%0d: got rv=%b op=%h want rv=%b op=%h", c, rsp_valid, out_op, e[16], e[15:0]);
            end
            c++;
            @(negedge CLK);
        end
        other_owner = 1'b0;
        exp_q = '{17'h0_FC05, 17'h0_1C5A, 17'h0_FC00, 17'h0_FCFF, 17'h0_0000};
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if ({rsp_valid, out_op} !== e) begin
                bad++;
                $display("FAIL contention_grant c%0d: got rv=%b op=%h want rv=%b op=%h", c, rsp_valid, out_op, e[16], e[15:0]);
            end
            c++;
            @(negedge CLK);
        end
    endtask

    task automatic test_fifo_full();
        logic [16:0] e;
        int c = 0;
        do_reset();
        prio = 4'd7;
        other_owner = 1'b1;
        for (int i = 1; i <= 4; i++) push_cmd(2'b01, 8'(i));
        total++;
        if (cmd_ready !== 1'b0) begin bad++; $display("FAIL fifo_full_ready: got %b want 0", cmd_ready); end
        push_cmd(2'b01, 8'h55);
        total++;
        if (cmd_ready !== 1'b0) begin bad++; $display("FAIL fifo_full_reject: got ready=%b want 0", cmd_ready); end
        other_owner = 1'b0;
        @(negedge CLK);
        exp_q = '{17'h0_1C01, 17'h0_FC00, 17'h0_1C02, 17'h0_FC00, 17'h0_FCFF,
                  17'h0_0000, 17'h0_FC07, 17'h0_FC07, 17'h0_FC07, 17'h0_1C03,
                  17'h0_FC00, 17'h0_1C04, 17'h0_FC00, 17'h0_FCFF, 17'h0_0000,
                  17'h0_0000, 17'h0_0000};
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if ({rsp_valid, out_op} !== e) begin
                bad++;
                $display("FAIL fifo_full_seq c%0d: got rv=%b op=%h want rv=%b op=%h", c, rsp_valid, out_op, e[16], e[15:0]);
            end
            if (c < 2) begin
                total++;
                if (cmd_ready !== (c == 1)) begin
                    bad++;
                    $display("FAIL fifo_full_ready_c%0d: got %b want %b", c, cmd_ready, (c == 1));
                end
            end
            c++;
            @(negedge CLK);
        end
    endtask

    task automatic test_prio_zero();
        logic [16:0] e;
        int c = 0;
        do_reset();
        prio = 4'd0;
        push_cmd(2'b10, 8'h00);
        push_cmd(2'b11, 8'h00);
        exp_q = '{17'h0_FC01, 17'h0_FC01, 17'h0_FC01, 17'h0_2C00, 17'h0_FC00,
                  17'h0_3C00, 17'h0_FC00, 17'h0_FCFF, 17'h0_0000, 17'h0_0000};
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if ({rsp_valid, out_op} !== e) begin
                bad++;
                $display("FAIL prio_zero c%0d: got rv=%b op=%h want rv=%b op=%h", c, rsp_valid, out_op, e[16], e[15:0]);
            end
            c++;
            @(negedge CLK);
        end
    endtask

    task automatic test_reset_gap();
        logic [16:0] e;
        int c = 0;
        do_reset();
        prio = 4'd2;
        push_cmd(2'b01, 8'h77);
        push_cmd(2'b01, 8'h78);
        exp_q = '{17'h0_FC02, 17'h0_FC02, 17'h0_FC02, 17'h0_1C77};
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if ({rsp_valid, out_op} !== e) begin
                bad++;
                $display("FAIL reset_gap_pre c%0d: got rv=%b op=%h want rv=%b op=%h", c, rsp_valid, out_op, e[16], e[15:0]);
            end
            c++;
            @(negedge CLK);
        end
        total++;
        if ({busy, out_op} !== 17'h1_FC00) begin bad++; $display("FAIL reset_gap_in_gap: got busy=%b op=%h want 1/FC00", busy, out_op); end
        RST = 1'b1;
        #1;
        total++;
        if ({busy, out_op} !== 17'h0_0000) begin bad++; $display("FAIL reset_gap_async: got busy=%b op=%h want 0/0000", busy, out_op); end
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_gap_ready: got %b want 1", cmd_ready); end
        total++;
        if (rsp_data !== 8'h00) begin bad++; $display("FAIL reset_gap_rsp_data: got %h want 00", rsp_data); end
        @(negedge CLK);
        RST = 1'b0;
        c = 0;
        repeat (6) exp_q.push_back(17'h0_0000);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if ({busy, out_op} !== e) begin
                bad++;
                $display("FAIL reset_gap_quiet c%0d: got busy=%b op=%h want busy=%b op=%h", c, busy, out_op, e[16], e[15:0]);
            end
            c++;
            @(negedge CLK);
        end
        c = 0;
        push_cmd(2'b01, 8'h99);
        exp_q = '{17'h0_0000, 17'h0_FC02, 17'h0_FC02, 17'h0_FC02, 17'h0_1C99,
                  17'h0_FC00, 17'h0_FCFF, 17'h0_0000, 17'h0_0000};
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if ({rsp_valid, out_op} !== e) begin
                bad++;
                $display("FAIL reset_gap_after c%0d: got rv=%b op=%h want rv=%b op=%h", c, rsp_valid, out_op, e[16], e[15:0]);
            end
            c++;
            @(negedge CLK);
        end
    endtask

    // sequence and final report
    initial begin
        cmd_valid   = 1'b0;
        cmd_op      = 2'b00;
        cmd_arg     = 8'h00;
        prio        = 4'd1;
        other_owner = 1'b0;
        test_reset();
        test_single_write();
        test_write_read();
        test_burst_cap();
        test_contention();
        test_fifo_full();
        test_prio_zero();
        test_reset_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
